// File: rtl/bp_cacc_vdp_chunked.sv
// Chunked vector dot-product engine: CSR-configured, streams A/B through a
// single-outstanding memory port, reduces lanes_p products per chunk into a 64-bit accumulator.
module bp_cacc_vdp_chunked #(
    parameter int unsigned lanes_p       = 8,
    parameter int unsigned max_len_p     = 256,
    parameter int unsigned paddr_width_p = 40,
    parameter int unsigned dword_width_p = 64
) (
    input  logic                     clk_i,
    input  logic                     reset_n_i,
    input  logic                     csr_v_i,
    input  logic                     csr_w_i,
    input  logic [7:0]               csr_addr_i,
    input  logic [dword_width_p-1:0] csr_data_i,
    output logic                     csr_ready_o,
    output logic                     csr_resp_v_o,
    output logic [dword_width_p-1:0] csr_resp_data_o,
    input  logic                     csr_resp_yumi_i,
    output logic                     mem_req_v_o,
    output logic                     mem_req_w_o,
    output logic [paddr_width_p-1:0] mem_req_addr_o,
    output logic [dword_width_p-1:0] mem_req_data_o,
    input  logic                     mem_req_ready_i,
    input  logic                     mem_resp_v_i,
    input  logic [dword_width_p-1:0] mem_resp_data_i,
    output logic                     done_o
);

    localparam int unsigned DW    = dword_width_p;
    localparam int unsigned PAW   = paddr_width_p;
    localparam int unsigned IDX_W = $clog2(max_len_p + 1);
    localparam int unsigned K_W   = $clog2(lanes_p + 1);

    localparam logic [7:0] ADDR_A_PTR   = 8'h00;
    localparam logic [7:0] ADDR_B_PTR   = 8'h08;
    localparam logic [7:0] ADDR_LEN     = 8'h10;
    localparam logic [7:0] ADDR_START   = 8'h18;
    localparam logic [7:0] ADDR_STATUS  = 8'h20;
    localparam logic [7:0] ADDR_RES_PTR = 8'h28;
    localparam logic [7:0] ADDR_RESULT  = 8'h30;
    localparam logic [7:0] ADDR_OP      = 8'h38;
    localparam logic [7:0] ADDR_ABORT   = 8'h40;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LD_A,
        S_LD_B,
        S_REDUCE,
        S_ST,
        S_WAIT_ST,
        S_FIN
    } state_e;

    state_e           r_state;
    logic [DW-1:0]    r_a_ptr;
    logic [DW-1:0]    r_b_ptr;
    logic [DW-1:0]    r_len;
    logic [DW-1:0]    r_res_ptr;
    logic [DW-1:0]    r_result;
    logic [DW-1:0]    r_acc;
    logic             r_op;
    logic             r_busy;
    logic             r_done;
    logic             r_err;
    logic             r_abort_pend;
    logic [IDX_W-1:0] r_idx;
    logic [K_W-1:0]   r_k;
    logic [DW-1:0]    r_lane_a [lanes_p];
    logic [DW-1:0]    r_lane_b [lanes_p];
    logic             r_req_v;
    logic             r_req_w;
    logic [PAW-1:0]   r_req_addr;
    logic [DW-1:0]    r_req_data;
    logic             r_outst;
    logic             r_done_o;
    logic             r_resp_v;
    logic [DW-1:0]    r_resp_data;

    logic             w_csr_acc;
    logic             w_csr_wr;
    logic             w_start;
    logic             w_abort;
    logic             w_len_bad;
    logic             w_quiet;
    logic             w_abort_now;
    logic [DW-1:0]    w_rem;
    logic [DW-1:0]    w_elem_off;
    logic [DW-1:0]    w_rd_data;
    logic [DW-1:0]    w_dot;
    logic [K_W-1:0]   w_n;
    logic [IDX_W-1:0] w_idx_next;

    assign w_csr_acc  = csr_v_i & ~r_resp_v;
    assign w_csr_wr   = w_csr_acc & csr_w_i;
    assign w_start    = w_csr_wr & (csr_addr_i == ADDR_START) & csr_data_i[0];
    assign w_abort    = w_csr_wr & (csr_addr_i == ADDR_ABORT);
    assign w_len_bad  = (r_len == '0) || (r_len > DW'(max_len_p));
    assign w_quiet    = ~r_req_v & ~r_outst;
    assign w_rem      = r_len - DW'(r_idx);
    assign w_n        = (w_rem >= DW'(lanes_p)) ? K_W'(lanes_p) : K_W'(w_rem);
    assign w_idx_next = r_idx + IDX_W'(w_n);
    assign w_elem_off = (DW'(r_idx) + DW'(r_k)) << 3;

    assign csr_ready_o     = ~r_resp_v;
    assign csr_resp_v_o    = r_resp_v;
    assign csr_resp_data_o = r_resp_data;
    assign mem_req_v_o     = r_req_v;
    assign mem_req_w_o     = r_req_w;
    assign mem_req_addr_o  = r_req_addr;
    assign mem_req_data_o  = r_req_data;
    assign done_o          = r_done_o;

    // Chunk reduction: products and sums wrap modulo 2^64
    always_comb begin
        w_dot = '0;
        for (int k = 0; k < int'(lanes_p); k++) begin
            w_dot = w_dot + r_lane_a[k] * r_lane_b[k];
        end
    end

    always_comb begin
        w_rd_data = '0;
        case (csr_addr_i)
            ADDR_A_PTR:   w_rd_data = r_a_ptr;
            ADDR_B_PTR:   w_rd_data = r_b_ptr;
            ADDR_LEN:     w_rd_data = r_len;
            ADDR_STATUS:  w_rd_data = DW'({r_err, r_done, r_busy});
            ADDR_RES_PTR: w_rd_data = r_res_ptr;
            ADDR_RESULT:  w_rd_data = r_result;
            ADDR_OP:      w_rd_data = DW'(r_op);
            default:      ;
        endcase
    end

    // A pending abort lands only once no request or response is in flight
    always_comb begin
        w_abort_now = 1'b0;
        if (r_abort_pend) begin
            case (r_state)
                S_LD_A, S_LD_B, S_REDUCE, S_ST: w_abort_now = w_quiet;
                S_WAIT_ST:                      w_abort_now = mem_resp_v_i;
                default:                        ;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_state      <= S_IDLE;
            r_a_ptr      <= '0;
            r_b_ptr      <= '0;
            r_len        <= '0;
            r_res_ptr    <= '0;
            r_result     <= '0;
            r_acc        <= '0;
            r_op         <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
            r_abort_pend <= 1'b0;
            r_idx        <= '0;
            r_k          <= '0;
            for (int k = 0; k < int'(lanes_p); k++) begin
                r_lane_a[k] <= '0;
                r_lane_b[k] <= '0;
            end
            r_req_v      <= 1'b0;
            r_req_w      <= 1'b0;
            r_req_addr   <= '0;
            r_req_data   <= '0;
            r_outst      <= 1'b0;
            r_done_o     <= 1'b0;
            r_resp_v     <= 1'b0;
            r_resp_data  <= '0;
        end else begin
            r_done_o <= 1'b0;

            if (r_resp_v) begin
                if (csr_resp_yumi_i) r_resp_v <= 1'b0;
            end else if (csr_v_i) begin
                r_resp_v    <= 1'b1;
                r_resp_data <= csr_w_i ? '0 : w_rd_data;
            end

            // Config registers are frozen while a run is in progress
            if (w_csr_wr && !r_busy) begin
                case (csr_addr_i)
                    ADDR_A_PTR:   r_a_ptr   <= csr_data_i;
                    ADDR_B_PTR:   r_b_ptr   <= csr_data_i;
                    ADDR_LEN:     r_len     <= csr_data_i;
                    ADDR_RES_PTR: r_res_ptr <= csr_data_i;
                    ADDR_OP:      r_op      <= csr_data_i[0];
                    default:      ;
                endcase
            end
            if (w_start || w_abort) begin
                r_done <= 1'b0;
                r_err  <= 1'b0;
            end
            if (w_abort && r_busy) r_abort_pend <= 1'b1;

            if (w_abort_now) begin
                r_state      <= S_IDLE;
                r_busy       <= 1'b0;
                r_err        <= 1'b1;
                r_done       <= 1'b1;
                r_done_o     <= 1'b1;
                r_abort_pend <= 1'b0;
                r_outst      <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (w_start) begin
                            r_idx <= '0;
                            r_acc <= r_op ? r_result : '0;
                            if (w_len_bad) begin
                                r_err    <= 1'b1;
                                r_done   <= 1'b1;
                                r_done_o <= 1'b1;
                            end else begin
                                r_busy  <= 1'b1;
                                r_k     <= '0;
                                r_state <= S_LD_A;
                                for (int k = 0; k < int'(lanes_p); k++) begin
                                    r_lane_a[k] <= '0;
                                    r_lane_b[k] <= '0;
                                end
                            end
                        end
                    end
                    S_LD_A, S_LD_B: begin
                        if (r_req_v) begin
                            if (mem_req_ready_i) begin
                                r_req_v <= 1'b0;
                                r_outst <= 1'b1;
                            end
                        end else if (r_outst) begin
                            if (mem_resp_v_i) begin
                                r_outst <= 1'b0;
                                r_k     <= r_k + K_W'(1);
                                for (int k = 0; k < int'(lanes_p); k++) begin
                                    if (K_W'(k) == r_k) begin
                                        if (r_state == S_LD_A) r_lane_a[k] <= mem_resp_data_i;
                                        else                   r_lane_b[k] <= mem_resp_data_i;
                                    end
                                end
                            end
                        end else if (r_k == w_n) begin
                            r_k     <= '0;
                            r_state <= (r_state == S_LD_A) ? S_LD_B : S_REDUCE;
                        end else begin
                            r_req_v    <= 1'b1;
                            r_req_w    <= 1'b0;
                            r_req_data <= '0;
                            r_req_addr <= PAW'(((r_state == S_LD_A) ? r_a_ptr : r_b_ptr) + w_elem_off);
                        end
                    end
                    S_REDUCE: begin
                        r_acc <= r_acc + w_dot;
                        r_idx <= w_idx_next;
                        r_k   <= '0;
                        if (DW'(w_idx_next) == r_len) begin
                            r_state <= S_ST;
                        end else begin
                            r_state <= S_LD_A;
                            for (int k = 0; k < int'(lanes_p); k++) begin
                                r_lane_a[k] <= '0;
                                r_lane_b[k] <= '0;
                            end
                        end
                    end
                    S_ST: begin
                        if (r_req_v) begin
                            if (mem_req_ready_i) begin
                                r_req_v <= 1'b0;
                                r_outst <= 1'b1;
                                r_state <= S_WAIT_ST;
                            end
                        end else begin
                            r_req_v    <= 1'b1;
                            r_req_w    <= 1'b1;
                            r_req_addr <= PAW'(r_res_ptr);
                            r_req_data <= r_acc;
                        end
                    end
                    S_WAIT_ST: begin
                        if (mem_resp_v_i) begin
                            r_outst <= 1'b0;
                            r_state <= S_FIN;
                        end
                    end
                    S_FIN: begin
                        r_result     <= r_acc;
                        r_busy       <= 1'b0;
                        r_done       <= 1'b1;
                        r_done_o     <= 1'b1;
                        r_abort_pend <= 1'b0;
                        r_state      <= S_IDLE;
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    a_no_stray_resp: assert property (@(posedge clk_i) disable iff (!reset_n_i)
        mem_resp_v_i |-> r_outst);

endmodule

// File: tb/tb_bp_cacc_vdp_chunked.sv
// Directed bench for bp_cacc_vdp_chunked with a single-outstanding memory model.
module tb_bp_cacc_vdp_chunked;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        csr_v = 1'b0;
    logic        csr_w = 1'b0;
    logic [7:0]  csr_addr = '0;
    logic [63:0] csr_data = '0;
    logic        csr_yumi = 1'b0;
    logic        mem_ready = 1'b1;
    logic        mem_resp_v;
    logic [63:0] mem_resp_data;

    logic        csr_ready_o;
    logic        csr_resp_v_o;
    logic [63:0] csr_resp_data_o;
    logic        mem_req_v_o;
    logic        mem_req_w_o;
    logic [39:0] mem_req_addr_o;
    logic [63:0] mem_req_data_o;
    logic        done_o;

    int errs = 0;
    int checks = 0;

    always #5 clk = ~clk;

    bp_cacc_vdp_chunked #(
        .lanes_p(8), .max_len_p(256), .paddr_width_p(40), .dword_width_p(64)
    ) dut (
        .clk_i(clk), .reset_n_i(rst_n),
        .csr_v_i(csr_v), .csr_w_i(csr_w), .csr_addr_i(csr_addr), .csr_data_i(csr_data),
        .csr_ready_o(csr_ready_o), .csr_resp_v_o(csr_resp_v_o),
        .csr_resp_data_o(csr_resp_data_o), .csr_resp_yumi_i(csr_yumi),
        .mem_req_v_o(mem_req_v_o), .mem_req_w_o(mem_req_w_o),
        .mem_req_addr_o(mem_req_addr_o), .mem_req_data_o(mem_req_data_o),
        .mem_req_ready_i(mem_ready), .mem_resp_v_i(mem_resp_v),
        .mem_resp_data_i(mem_resp_data), .done_o(done_o)
    );

    // Memory model: answers each accepted request after lat cycles
    logic [63:0] mem [bit [39:0]];
    int          lat = 1;
    int          cnt;
    logic        pend;
    logic [63:0] pdata;
    int          ld_cnt = 0;
    int          st_cnt = 0;
    logic [39:0] ld_log [512];
    logic [39:0] st_addr;
    logic [63:0] st_data;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_resp_v    <= 1'b0;
            mem_resp_data <= '0;
            pend          <= 1'b0;
            cnt           <= 0;
            pdata         <= '0;
        end else begin
            mem_resp_v <= 1'b0;
            if (pend) begin
                if (cnt <= 1) begin
                    pend          <= 1'b0;
                    mem_resp_v    <= 1'b1;
                    mem_resp_data <= pdata;
                end else begin
                    cnt <= cnt - 1;
                end
            end
            if (mem_req_v_o && mem_ready) begin
                pend <= 1'b1;
                cnt  <= lat;
                if (mem_req_w_o) begin
                    st_addr <= mem_req_addr_o;
                    st_data <= mem_req_data_o;
                    pdata   <= '0;
                    st_cnt++;
                end else begin
                    ld_log[ld_cnt % 512] <= mem_req_addr_o;
                    pdata <= mem.exists(mem_req_addr_o) ? mem[mem_req_addr_o] : 64'd0;
                    ld_cnt++;
                end
            end
        end
    end

    int done_cnt = 0;
    always @(posedge clk) if (done_o) done_cnt++;

    // Stalled request must keep addr/data/w unchanged
    int          stab_viol = 0;
    int          hold_cycles = 0;
    logic        hold_prev = 1'b0;
    logic [39:0] haddr;
    logic [63:0] hdata;
    logic        hw;
    always @(posedge clk) begin
        if (hold_prev && (!mem_req_v_o || mem_req_addr_o != haddr ||
                          mem_req_data_o != hdata || mem_req_w_o != hw))
            stab_viol++;
        hold_prev = mem_req_v_o && !mem_ready;
        haddr     = mem_req_addr_o;
        hdata     = mem_req_data_o;
        hw        = mem_req_w_o;
        if (hold_prev) hold_cycles++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic csr_op(input logic w, input logic [7:0] a, input logic [63:0] d,
                          output logic [63:0] rd);
        int n;
        @(negedge clk);
        n = 0;
        while (!csr_ready_o && n < 20) begin @(negedge clk); n++; end
        csr_v = 1'b1; csr_w = w; csr_addr = a; csr_data = d;
        @(negedge clk);
        csr_v = 1'b0;
        n = 0;
        while (!csr_resp_v_o && n < 20) begin @(negedge clk); n++; end
        if (!csr_resp_v_o) check("csr_resp_timeout", 64'(csr_resp_v_o), 64'd1);
        rd = csr_resp_data_o;
        csr_yumi = 1'b1;
        @(negedge clk);
        csr_yumi = 1'b0;
    endtask

    task automatic wr(input logic [7:0] a, input logic [63:0] d);
        logic [63:0] dummy;
        csr_op(1'b1, a, d, dummy);
    endtask

    task automatic rd(input logic [7:0] a, output logic [63:0] v);
        csr_op(1'b0, a, '0, v);
    endtask

    task automatic setup(input logic [63:0] ap, input logic [63:0] bp, input logic [63:0] len,
                         input logic [63:0] rp, input logic [63:0] op);
        wr(8'h00, ap); wr(8'h08, bp); wr(8'h10, len); wr(8'h28, rp); wr(8'h38, op);
    endtask

    task automatic wait_done(input int base);
        int n = 0;
        while (done_cnt == base && n < 3000) begin @(negedge clk); n++; end
        if (done_cnt == base) check("done_timeout", 64'(done_cnt - base), 64'd1);
        repeat (3) @(negedge clk);
    endtask

    task automatic wait_loads(input int target);
        int n = 0;
        while (ld_cnt < target && n < 500) begin @(negedge clk); n++; end
        if (ld_cnt < target) check("load_wait_timeout", 64'(ld_cnt), 64'(target));
    endtask

    task automatic wait_req();
        int n = 0;
        while (!mem_req_v_o && n < 500) begin @(negedge clk); n++; end
        if (!mem_req_v_o) check("req_wait_timeout", 64'(mem_req_v_o), 64'd1);
    endtask

    logic [63:0] v;
    int b_ld, b_st, b_dn, b_hold;

    initial begin
        mem[40'h100] = 64'd1; mem[40'h108] = 64'd2; mem[40'h110] = 64'd3;
        mem[40'h200] = 64'd4; mem[40'h208] = 64'd5; mem[40'h210] = 64'd6;
        for (int i = 0; i < 20; i++) begin
            mem[40'h2000 + 40'(i * 8)] = 64'(i + 1);
            mem[40'h3000 + 40'(i * 8)] = 64'd1;
        end
        mem[40'h4000] = 64'h8000_0000_0000_0000; mem[40'h4008] = 64'h8000_0000_0000_0000;
        mem[40'h4100] = 64'd2;                    mem[40'h4108] = 64'd1;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_req_v", 64'(mem_req_v_o), 64'd0);
        check("rst_done", 64'(done_o), 64'd0);
        check("rst_resp_v", 64'(csr_resp_v_o), 64'd0);
        check("rst_req_addr", 64'(mem_req_addr_o), 64'd0);
        rst_n = 1'b1;
        rd(8'h20, v); check("rst_status", v, 64'd0);
        rd(8'h30, v); check("rst_result", v, 64'd0);

        // Short vector, single partial chunk
        b_ld = ld_cnt; b_st = st_cnt; b_dn = done_cnt;
        setup(64'h100, 64'h200, 64'd3, 64'h1000, 64'd0);
        wr(8'h18, 64'd1);
        wait_done(b_dn);
        check("t1_loads", 64'(ld_cnt - b_ld), 64'd6);
        check("t1_stores", 64'(st_cnt - b_st), 64'd1);
        check("t1_ld_a0", 64'(ld_log[b_ld]), 64'h100);
        check("t1_ld_a2", 64'(ld_log[b_ld + 2]), 64'h110);
        check("t1_ld_b0", 64'(ld_log[b_ld + 3]), 64'h200);
        check("t1_ld_b2", 64'(ld_log[b_ld + 5]), 64'h210);
        check("t1_st_addr", 64'(st_addr), 64'h1000);
        check("t1_st_data", st_data, 64'd32);
        check("t1_done_pulses", 64'(done_cnt - b_dn), 64'd1);
        rd(8'h30, v); check("t1_result", v, 64'd32);
        rd(8'h20, v); check("t1_status", v, 64'h2);

        // Multi-chunk 8/8/4
        b_ld = ld_cnt; b_st = st_cnt; b_dn = done_cnt;
        setup(64'h2000, 64'h3000, 64'd20, 64'h1100, 64'd0);
        wr(8'h18, 64'd1);
        wait_done(b_dn);
        check("t2_loads", 64'(ld_cnt - b_ld), 64'd40);
        check("t2_stores", 64'(st_cnt - b_st), 64'd1);
        check("t2_ld_b_chunk0", 64'(ld_log[b_ld + 8]), 64'h3000);
        check("t2_ld_a_chunk1", 64'(ld_log[b_ld + 16]), 64'h2040);
        check("t2_ld_last", 64'(ld_log[b_ld + 39]), 64'h3098);
        check("t2_st_data", st_data, 64'd210);
        rd(8'h30, v); check("t2_result", v, 64'd210);

        // Illegal lengths
        b_ld = ld_cnt; b_st = st_cnt; b_dn = done_cnt;
        wr(8'h10, 64'd0);
        wr(8'h18, 64'd1);
        wait_done(b_dn);
        rd(8'h20, v); check("t3_len0_status", v, 64'h6);
        check("t3_len0_done", 64'(done_cnt - b_dn), 64'd1);
        b_dn = done_cnt;
        wr(8'h10, 64'd257);
        wr(8'h18, 64'd1);
        wait_done(b_dn);
        rd(8'h20, v); check("t3_lenmax_status", v, 64'h6);
        check("t3_lenmax_done", 64'(done_cnt - b_dn), 64'd1);
        check("t3_no_mem", 64'((ld_cnt - b_ld) + (st_cnt - b_st)), 64'd0);
        rd(8'h30, v); check("t3_result_kept", v, 64'd210);
        rd(8'h48, v); check("t3_unmapped_rd", v, 64'd0);

        // Accumulate mode
        b_dn = done_cnt;
        setup(64'h100, 64'h200, 64'd3, 64'h1000, 64'd0);
        wr(8'h18, 64'd1); wait_done(b_dn);
        rd(8'h30, v); check("t4_op0_first", v, 64'd32);
        b_dn = done_cnt;
        wr(8'h38, 64'd1); wr(8'h18, 64'd1); wait_done(b_dn);
        rd(8'h30, v); check("t4_op1_acc", v, 64'd64);
        b_dn = done_cnt;
        wr(8'h38, 64'd0); wr(8'h18, 64'd1); wait_done(b_dn);
        rd(8'h30, v); check("t4_op0_clear", v, 64'd32);

        // Wrapping products/sums and a stalled first request
        b_dn = done_cnt; b_hold = hold_cycles;
        setup(64'h4000, 64'h4100, 64'd2, 64'h1800, 64'd0);
        mem_ready = 1'b0;
        wr(8'h18, 64'd1);
        wait_req();
        repeat (5) @(negedge clk);
        mem_ready = 1'b1;
        wait_done(b_dn);
        check("t5_stall_seen", 64'(hold_cycles - b_hold >= 5), 64'd1);
        check("t5_stable", 64'(stab_viol), 64'd0);
        check("t5_st_data", st_data, 64'h8000_0000_0000_0000);
        rd(8'h30, v); check("t5_result", v, 64'h8000_0000_0000_0000);

        // Abort in LD_B with a response outstanding
        lat = 10;
        b_ld = ld_cnt; b_st = st_cnt; b_dn = done_cnt;
        setup(64'h100, 64'h200, 64'd3, 64'h1000, 64'd0);
        wr(8'h18, 64'd1);
        wr(8'h10, 64'd5);
        wait_loads(b_ld + 4);
        wr(8'h40, 64'd1);
        wait_done(b_dn);
        lat = 1;
        rd(8'h20, v); check("t6_status", v, 64'h6);
        check("t6_stores", 64'(st_cnt - b_st), 64'd0);
        check("t6_loads", 64'(ld_cnt - b_ld), 64'd4);
        check("t6_done_pulses", 64'(done_cnt - b_dn), 64'd1);
        rd(8'h30, v); check("t6_result_kept", v, 64'h8000_0000_0000_0000);
        rd(8'h10, v); check("t6_busy_wr_dropped", v, 64'd3);

        // Reset in the middle of LD_A, then a clean run
        b_ld = ld_cnt;
        wr(8'h18, 64'd1);
        wait_loads(b_ld + 1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("t7_rst_req_v", 64'(mem_req_v_o), 64'd0);
        check("t7_rst_req_addr", 64'(mem_req_addr_o), 64'd0);
        check("t7_rst_done", 64'(done_o), 64'd0);
        check("t7_rst_resp_v", 64'(csr_resp_v_o), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        rd(8'h20, v); check("t7_status", v, 64'd0);
        rd(8'h00, v); check("t7_a_ptr", v, 64'd0);
        b_ld = ld_cnt; b_st = st_cnt; b_dn = done_cnt;
        setup(64'h100, 64'h200, 64'd3, 64'h1000, 64'd0);
        wr(8'h18, 64'd1);
        wait_done(b_dn);
        check("t7_loads", 64'(ld_cnt - b_ld), 64'd6);
        check("t7_stores", 64'(st_cnt - b_st), 64'd1);
        rd(8'h30, v); check("t7_result", v, 64'd32);
        rd(8'h20, v); check("t7_status_done", v, 64'h2);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
